anton_neopixel_sequencer: RTL and testbench

Timing and sequencing stage that sits directly upstream of the NeoPixel bit-stream output stage. It generates the transmit/reset state, the byte index into the pixel buffer, the 0-23 bit index inside a pixel, and the 0-7 pattern-slot index. The output stage turns these into the serial waveform. Each data bit is 8 clock slots, each pixel is 24 bits, and every frame is followed by a latch/reset low period.

---
 rtl/anton_neopixel_sequencer_pkg.sv | 22 ++
 rtl/anton_neopixel_sequencer_if.sv | 36 +++
 rtl/anton_neopixel_reset_timer.sv | 46 ++++
 rtl/anton_neopixel_sequencer.sv | 114 +++++++++++
 tb/tb_anton_neopixel_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/anton_neopixel_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anton_neopixel_sequencer_pkg : shared types, framing constants, clog2      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package anton_neopixel_sequencer_pkg;

  typedef enum logic {
    ST_RESET    = 1'b0,
    ST_TRANSMIT = 1'b1
  } state_e;

  localparam int BITS_PER_PIXEL = 24;
  localparam int SLOTS_PER_BIT  = 8;

  // Never returns zero so a degenerate size still yields a legal vector width.
  function automatic int f_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/anton_neopixel_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anton_neopixel_sequencer_if : control inputs and sequencing outputs        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface anton_neopixel_sequencer_if
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int BUFFER_END = 7
);
  localparam int BUFFER_BITS = f_clog2(BUFFER_END + 1);

  logic                   reg_ctrl_run;
  logic                   reg_ctrl_loop;
  logic                   reg_ctrl_32bit;
  logic [BUFFER_BITS-1:0] reg_max;
  logic                   state;
  logic [BUFFER_BITS-1:0] pixel_index;
  logic [4:0]             pixel_bit_index;
  logic [2:0]             bit_pattern_index;
  logic                   stream_sync;
  logic                   stream_done;

  modport master (
    output reg_ctrl_run, reg_ctrl_loop, reg_ctrl_32bit, reg_max,
    input  state, pixel_index, pixel_bit_index, bit_pattern_index,
           stream_sync, stream_done
  );

  modport slave (
    input  reg_ctrl_run, reg_ctrl_loop, reg_ctrl_32bit, reg_max,
    output state, pixel_index, pixel_bit_index, bit_pattern_index,
           stream_sync, stream_done
  );
endinterface
`default_nettype wire

// File: rtl/anton_neopixel_reset_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anton_neopixel_reset_timer : inter-frame latch delay, busy for RESET_DELAY |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module anton_neopixel_reset_timer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int RESET_DELAY = 400
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_start,
  output logic      o_done,
  output logic      o_busy
);
  localparam int               CNT_W  = f_clog2(RESET_DELAY);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(RESET_DELAY - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == c_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Terminal-count flag: high during the final busy cycle.
  assign o_done = r_busy && (r_cnt == c_LAST);
  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/anton_neopixel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anton_neopixel_sequencer : frame/pixel/bit/slot sequencing for NeoPixel tx |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module anton_neopixel_sequencer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int BUFFER_END  = 7,
  parameter int RESET_DELAY = 400
) (
  input  wire logic                  clk7mhz,
  input  wire logic                  syncReset,
  anton_neopixel_sequencer_if.slave  io_bus
);
  localparam int                     BUFFER_BITS  = f_clog2(BUFFER_END + 1);
  localparam logic [4:0]             c_LAST_BIT   = 5'(BITS_PER_PIXEL - 1);
  localparam logic [2:0]             c_LAST_SLOT  = 3'(SLOTS_PER_BIT - 1);
  localparam logic [BUFFER_BITS:0]   c_BUF_END_W  = (BUFFER_BITS + 1)'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] c_BUF_END    = BUFFER_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS:0]   c_STEP_32    = (BUFFER_BITS + 1)'(4);
  localparam logic [BUFFER_BITS:0]   c_STEP_8     = (BUFFER_BITS + 1)'(1);

  state_e                 r_state;
  logic [BUFFER_BITS-1:0] r_pixel_index;
  logic [4:0]             r_bit;
  logic [2:0]             r_slot;
  logic                   r_cfg_32bit;
  logic [BUFFER_BITS-1:0] r_cfg_max;
  logic                   r_done;
  logic                   r_wait;

  logic [BUFFER_BITS-1:0] w_max_clamped;
  logic [BUFFER_BITS:0]   w_pix_next;
  logic                   w_last_pixel;
  logic                   w_frame_end;
  logic                   w_frame_start;
  logic                   w_timer_done;
  logic                   w_timer_busy;

  always_comb begin
    w_max_clamped = ({1'b0, io_bus.reg_max} > c_BUF_END_W) ? c_BUF_END : io_bus.reg_max;
    w_pix_next    = {1'b0, r_pixel_index} + (r_cfg_32bit ? c_STEP_32 : c_STEP_8);
    // A step that would leave the buffer also ends the frame.
    w_last_pixel  = (r_cfg_32bit ? ((r_pixel_index >> 2) == (r_cfg_max >> 2))
                                 : (r_pixel_index == r_cfg_max))
                    || (w_pix_next > c_BUF_END_W);
    w_frame_end   = (r_state == ST_TRANSMIT) && (r_slot == c_LAST_SLOT)
                    && (r_bit == c_LAST_BIT) && w_last_pixel;
    w_frame_start = (r_state == ST_RESET)
                    && (w_timer_done ? io_bus.reg_ctrl_loop : (!w_timer_busy && !r_wait));
  end

  anton_neopixel_reset_timer #(
    .RESET_DELAY (RESET_DELAY)
  ) u_reset_timer (
    .clk     (clk7mhz),
    .rst     (syncReset),
    .i_clear (!io_bus.reg_ctrl_run),
    .i_start (io_bus.reg_ctrl_run && w_frame_end),
    .o_done  (w_timer_done),
    .o_busy  (w_timer_busy)
  );

  always_ff @(posedge clk7mhz) begin
    if (syncReset || !io_bus.reg_ctrl_run) begin
      r_state       <= ST_RESET;
      r_pixel_index <= '0;
      r_bit         <= '0;
      r_slot        <= '0;
      r_cfg_32bit   <= 1'b0;
      r_cfg_max     <= '0;
      r_done        <= 1'b0;
      r_wait        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_frame_start) begin
        r_state       <= ST_TRANSMIT;
        r_pixel_index <= '0;
        r_bit         <= '0;
        r_slot        <= '0;
        r_cfg_32bit   <= io_bus.reg_ctrl_32bit;
        r_cfg_max     <= w_max_clamped;
      end else if (r_state == ST_TRANSMIT) begin
        if (w_frame_end) begin
          r_state       <= ST_RESET;
          r_pixel_index <= '0;
          r_bit         <= '0;
          r_slot        <= '0;
        end else begin
          r_slot <= r_slot + 3'd1;
          if (r_slot == c_LAST_SLOT) begin
            r_bit <= (r_bit == c_LAST_BIT) ? 5'd0 : r_bit + 5'd1;
            if (r_bit == c_LAST_BIT)
              r_pixel_index <= w_pix_next[BUFFER_BITS-1:0];
          end
        end
      end else if (w_timer_done) begin
        // Non-looping frame finished: pulse once, then hold until run re-arms.
        r_done <= 1'b1;
        r_wait <= 1'b1;
      end
    end
  end

  assign io_bus.state             = r_state;
  assign io_bus.pixel_index       = r_pixel_index;
  assign io_bus.pixel_bit_index   = r_bit;
  assign io_bus.bit_pattern_index = r_slot;
  assign io_bus.stream_sync       = w_timer_busy;
  assign io_bus.stream_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_anton_neopixel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_anton_neopixel_sequencer : directed vector bench for the sequencer      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_anton_neopixel_sequencer;

  logic clk;
  logic rst;

  anton_neopixel_sequencer_if #(.BUFFER_END(7)) bus ();

  anton_neopixel_sequencer #(
    .BUFFER_END  (7),
    .RESET_DELAY (400)
  ) dut (
    .clk7mhz   (clk),
    .syncReset (rst),
    .io_bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       b32;
    bit [2:0] max;
    int       exp_tx;
    int       exp_npix;
    int       exp_last;
  } vec_t;

  int n_pass;
  int n_total;

  int cyc, tx_cnt, sync_cnt, done_cnt, done_cyc, cur_len, low2_bad;
  int runs[$];
  int run_starts[$];
  int pix_seq[$];
  logic       prev_state;
  logic [2:0] prev_pix;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int outs();
    return int'({bus.state, bus.pixel_index, bus.pixel_bit_index,
                 bus.bit_pattern_index, bus.stream_sync, bus.stream_done});
  endfunction

  task automatic reset_stats();
    cyc = 0; tx_cnt = 0; sync_cnt = 0; done_cnt = 0; done_cyc = -1;
    cur_len = 0; low2_bad = 0;
    runs.delete(); run_starts.delete(); pix_seq.delete();
    prev_state = bus.state; prev_pix = bus.pixel_index;
  endtask

  task automatic sample();
    cyc++;
    if (bus.stream_sync) sync_cnt++;
    if (bus.stream_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.state) begin
      tx_cnt++;
      cur_len++;
      if (!prev_state) run_starts.push_back(cyc);
      if (!prev_state || bus.pixel_index != prev_pix) pix_seq.push_back(int'(bus.pixel_index));
      if (bus.pixel_index[1:0] != 2'b00) low2_bad++;
    end else if (prev_state) begin
      runs.push_back(cur_len);
      cur_len = 0;
    end
    prev_state = bus.state;
    prev_pix   = bus.pixel_index;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic go_idle();
    bus.reg_ctrl_run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    int  mism;
    bit  hit;
    n_pass = 0; n_total = 0;

    // {32bit, max, TRANSMIT cycles, pixels sent, last pixel index}
    vecs[0] = '{1'b0, 3'd2,  576, 3, 2};
    vecs[1] = '{1'b1, 3'd7,  384, 2, 4};
    vecs[2] = '{1'b0, 3'd0,  192, 1, 0};
    vecs[3] = '{1'b0, 3'd7, 1536, 8, 7};
    vecs[4] = '{1'b1, 3'd3,  192, 1, 0};
    vecs[5] = '{1'b1, 3'd5,  384, 2, 4};

    rst = 1'b1;
    bus.reg_ctrl_run   = 1'b1;
    bus.reg_ctrl_loop  = 1'b0;
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    bus.reg_ctrl_run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs(), 0);

    // Single non-looping frames
    foreach (vecs[v]) begin
      go_idle();
      bus.reg_ctrl_loop  = 1'b0;
      bus.reg_ctrl_32bit = vecs[v].b32;
      bus.reg_max        = vecs[v].max;
      reset_stats();
      bus.reg_ctrl_run = 1'b1;
      repeat (vecs[v].exp_tx + 430) step();
      chk($sformatf("v%0d_tx_cycles", v), tx_cnt, vecs[v].exp_tx);
      chk($sformatf("v%0d_frames", v), runs.size(), 1);
      chk($sformatf("v%0d_npix", v), pix_seq.size(), vecs[v].exp_npix);
      mism = 0;
      for (int j = 0; j < vecs[v].exp_npix; j++)
        if (q_at(pix_seq, j) != j * (vecs[v].b32 ? 4 : 1)) mism++;
      chk($sformatf("v%0d_pix_seq_errs", v), mism, 0);
      chk($sformatf("v%0d_last_pix", v), q_at(pix_seq, vecs[v].exp_npix - 1), vecs[v].exp_last);
      chk($sformatf("v%0d_sync_cycles", v), sync_cnt, 400);
      chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      chk($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_tx + 401);
      if (vecs[v].b32) chk($sformatf("v%0d_low2_nonzero", v), low2_bad, 0);
      chk($sformatf("v%0d_idle_after", v), outs(), 0);
    end

    // Looping, one pixel per frame
    go_idle();
    bus.reg_ctrl_loop  = 1'b1;
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 3'd0;
    reset_stats();
    bus.reg_ctrl_run = 1'b1;
    repeat (3 * 592 + 50) step();
    chk("loop_starts", run_starts.size(), 4);
    chk("loop_period_a", q_at(run_starts, 1) - q_at(run_starts, 0), 592);
    chk("loop_period_b", q_at(run_starts, 3) - q_at(run_starts, 2), 592);
    chk("loop_tx_len_0", q_at(runs, 0), 192);
    chk("loop_tx_len_2", q_at(runs, 2), 192);
    chk("loop_sync_cycles", sync_cnt, 1200);
    chk("loop_done_pulses", done_cnt, 0);
    bus.reg_ctrl_loop = 1'b0;

    // Abort at pixel 1, bit 10, slot 5, then restart
    go_idle();
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 3'd2;
    reset_stats();
    bus.reg_ctrl_run = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      step();
      hit = bus.state && bus.pixel_index == 3'd1 && bus.pixel_bit_index == 5'd10
            && bus.bit_pattern_index == 3'd5;
    end
    chk("abort_reached", int'(hit), 1);
    chk("abort_point_cycle", cyc, 278);
    bus.reg_ctrl_run = 1'b0;
    @(negedge clk);
    chk("abort_outputs", outs(), 0);
    bus.reg_ctrl_run = 1'b1;
    @(negedge clk);
    chk("abort_restart", outs(), 14'h2000);

    // Mid-frame config change applies to the next looped frame only
    go_idle();
    bus.reg_ctrl_loop  = 1'b1;
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 3'd2;
    reset_stats();
    bus.reg_ctrl_run = 1'b1;
    repeat (10) step();
    bus.reg_max        = 3'd0;
    bus.reg_ctrl_32bit = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      step();
      if (run_starts.size() >= 2) bus.reg_ctrl_loop = 1'b0;
    end
    chk("cfg_frames", runs.size(), 2);
    chk("cfg_frame0_len", q_at(runs, 0), 576);
    chk("cfg_frame1_len", q_at(runs, 1), 192);
    chk("cfg_frame0_last", q_at(pix_seq, 2), 2);
    chk("cfg_pix_entries", pix_seq.size(), 4);
    chk("cfg_done_pulses", done_cnt, 1);

    // syncReset during the reset period at counter 200
    go_idle();
    bus.reg_ctrl_loop  = 1'b0;
    bus.reg_ctrl_32bit = 1'b0;
    bus.reg_max        = 3'd0;
    reset_stats();
    bus.reg_ctrl_run = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      step();
      hit = bus.stream_sync && sync_cnt == 201;
    end
    chk("rst_point_reached", int'(hit), 1);
    chk("rst_point_cycle", cyc, 393);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart", outs(), 14'h2000);
    chk("rst_no_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
